// File: rtl/reg_file_sb.sv
// Two-read, one-write RV32 register file with a pending-write scoreboard.
// Optional write-to-read forwarding: define REG_FILE_SB_BYPASS_EN.
module reg_file_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] write_data,
    input  logic            read_en,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] out1,
    output logic [XLEN-1:0] out2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            busy1,
    output logic            busy2
);

    localparam int NREGS = 2 ** AW;

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [XLEN-1:0]  r_out1;
    logic [XLEN-1:0]  r_out2;

    logic             w_wr_en;
    logic             w_iss_en;
    logic [XLEN-1:0]  w_rd1;
    logic [XLEN-1:0]  w_rd2;
    logic [NREGS-1:0] w_pend_nxt;

    assign w_wr_en  = write && (rd != '0);
    assign w_iss_en = issue_valid && (issue_rd != '0);

    always_comb begin
        w_rd1 = (rs1 == '0) ? '0 : r_regs[rs1];
        w_rd2 = (rs2 == '0) ? '0 : r_regs[rs2];
`ifdef REG_FILE_SB_BYPASS_EN
        if (w_wr_en && (rd == rs1)) w_rd1 = write_data;
        if (w_wr_en && (rd == rs2)) w_rd2 = write_data;
`endif
    end

    // Clear first so a same-index issue (new producer) wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_en)  w_pend_nxt[rd]       = 1'b0;
        if (w_iss_en) w_pend_nxt[issue_rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[rd] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out1 <= '0;
            r_out2 <= '0;
        end else if (read_en) begin
            r_out1 <= w_rd1;
            r_out2 <= w_rd2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pend <= '0;
        else     r_pend <= w_pend_nxt;
    end

    assign out1 = r_out1;
    assign out2 = r_out2;

`ifdef REG_FILE_SB_BYPASS_EN
    logic w_rel1;
    logic w_rel2;

    // Writeback releases the consumer unless a new producer issues now.
    assign w_rel1 = write && (rd == rs1)
                 && !(issue_valid && (issue_rd == rs1));
    assign w_rel2 = write && (rd == rs2)
                 && !(issue_valid && (issue_rd == rs2));
    assign busy1 = r_pend[rs1] && !w_rel1;
    assign busy2 = r_pend[rs2] && !w_rel2;
`else
    assign busy1 = r_pend[rs1];
    assign busy2 = r_pend[rs2];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default and 64/4 builds).
`timescale 1ns/1ps
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] write_data = '0;
    logic        read_en = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] out1;
    logic [31:0] out2;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        busy1;
    logic        busy2;

    logic        p_write = 1'b0;
    logic [3:0]  p_rd = '0;
    logic [63:0] p_wd = '0;
    logic        p_read_en = 1'b0;
    logic [3:0]  p_rs1 = '0;
    logic [3:0]  p_rs2 = '0;
    logic [63:0] p_out1;
    logic [63:0] p_out2;
    logic        p_iv = 1'b0;
    logic [3:0]  p_ird = '0;
    logic        p_busy1;
    logic        p_busy2;

    int checks = 0;
    int failures = 0;
    bit bypass;

    always #5 clk = ~clk;

    reg_file_sb u_dut (
        .clk(clk), .rst(rst), .write(write), .rd(rd),
        .write_data(write_data), .read_en(read_en),
        .rs1(rs1), .rs2(rs2), .out1(out1), .out2(out2),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy1(busy1), .busy2(busy2)
    );

    reg_file_sb #(.XLEN(64), .AW(4)) u_dut64 (
        .clk(clk), .rst(rst), .write(p_write), .rd(p_rd),
        .write_data(p_wd), .read_en(p_read_en),
        .rs1(p_rs1), .rs2(p_rs2), .out1(p_out1), .out2(p_out2),
        .issue_valid(p_iv), .issue_rd(p_ird),
        .busy1(p_busy1), .busy2(p_busy2)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef REG_FILE_SB_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        #12;
        chk("rst_out1", out1, 0);
        chk("rst_out2", out2, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_busy2", busy2, 0);
        rst = 1'b0;

        write = 1; rd = 5; write_data = 32'hDEADBEEF;
        tick();
        write = 0;
        read_en = 1; rs1 = 5; issue_valid = 1; issue_rd = 5;
        tick();
        issue_valid = 0; read_en = 0;
        chk("pre_rst_out1", out1, 32'hDEADBEEF);
        chk("pre_rst_busy1", busy1, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_out1", out1, 0);
        chk("async_rst_busy1", busy1, 0);
        rst = 0;
        read_en = 1;
        tick();
        chk("post_rst_reg5", out1, 0);
        chk("post_rst_busy1", busy1, 0);

        write = 1; rd = 0; write_data = 32'hFFFFFFFF;
        tick();
        write = 0; rs1 = 0; rs2 = 0;
        tick();
        chk("x0_out1", out1, 0);
        chk("x0_out2", out2, 0);
        issue_valid = 1; issue_rd = 0;
        tick();
        issue_valid = 0;
        chk("x0_busy1", busy1, 0);

        read_en = 0;
        write = 1; rd = 3; write_data = 32'h11;
        tick();
        rd = 7; write_data = 32'h22;
        tick();
        write = 0; read_en = 1; rs1 = 3; rs2 = 7;
        tick();
        chk("dual_out1", out1, 32'h11);
        chk("dual_out2", out2, 32'h22);
        read_en = 0; rs1 = 7;
        tick();
        chk("hold_out1", out1, 32'h11);
        chk("hold_out2", out2, 32'h22);

        write = 1; rd = 4; write_data = 32'hA;
        tick();
        write_data = 32'hB; read_en = 1; rs1 = 4;
        tick();
        write = 0;
        chk("rw_same_out1", out1, bypass ? 32'hB : 32'hA);
        tick();
        chk("rw_after_out1", out1, 32'hB);
        read_en = 0;

        issue_valid = 1; issue_rd = 9;
        tick();
        issue_valid = 0; rs1 = 9;
        #1;
        chk("sb_busy_set", busy1, 1);
        write = 1; rd = 9; write_data = 32'h99;
        #1;
        chk("sb_busy_wb", busy1, bypass ? 0 : 1);
        tick();
        write = 0;
        chk("sb_busy_after", busy1, 0);

        issue_valid = 1; issue_rd = 9;
        tick();
        chk("sb_reissue", busy1, 1);
        write = 1; rd = 9;
        #1;
        chk("sb_set_clr_same", busy1, 1);
        tick();
        write = 0; issue_valid = 0;
        chk("sb_set_wins", busy1, 1);

        write = 1; rd = 9; issue_valid = 1; issue_rd = 10; rs2 = 10;
        tick();
        write = 0; issue_valid = 0;
        chk("sb_diff_clr", busy1, 0);
        chk("sb_diff_set", busy2, 1);
        write = 1; rd = 10;
        tick();
        write = 0;
        chk("sb_clr10", busy2, 0);
        write = 1; rd = 12; rs1 = 12;
        tick();
        write = 0;
        chk("sb_wr_nopend", busy1, 0);

        p_write = 1; p_rd = 15; p_wd = 64'h0123456789ABCDEF;
        tick();
        p_write = 0; p_read_en = 1; p_rs2 = 15;
        tick();
        p_read_en = 0;
        chk("p64_out2", p_out2, 64'h0123456789ABCDEF);
        chk("p64_busy2_idle", p_busy2, 0);
        p_iv = 1; p_ird = 15;
        tick();
        p_iv = 0;
        chk("p64_pend15_set", p_busy2, 1);
        p_rs1 = 14;
        #1;
        chk("p64_pend14_clr", p_busy1, 0);
        p_write = 1; p_rd = 15; p_wd = 64'h5;
        tick();
        p_write = 0;
        chk("p64_pend15_clr", p_busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-port-mode register file for the RV32 datapath.
- One write port and two synchronous read ports, all usable in the same cycle; x0 is hardwired to zero.
- Contains a per-register pending-write scoreboard, so the decode stage can stall on RAW hazards.
- Sits between decode (rs1/rs2/issue) and writeback (rd/write_data).

Parameters:
XLEN  32  data width of each register
AW  5  register address width; register count NREGS = 2**AW (localparam)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
write  in  1  writeback strobe; Reg[rd] <= write_data
rd  in  AW  writeback destination address
write_data  in  XLEN  writeback data
read_en  in  1  capture new read data this cycle
rs1  in  AW  read address, port 1
rs2  in  AW  read address, port 2
out1  out  XLEN  registered read data, port 1
out2  out  XLEN  registered read data, port 2
issue_valid  in  1  an instruction writing issue_rd is issued this cycle
issue_rd  in  AW  destination of the issued instruction
busy1  out  1  rs1 has a pending (unwritten) result
busy2  out  1  rs2 has a pending (unwritten) result

Behaviour:
- Reset (rst=1, asynchronous, at any time, including mid-operation):
  - all NREGS registers = 0
  - out1 = out2 = 0
  - all pending bits = 0, so busy1 = busy2 = 0
  - no test preload values: registers 1 and 2 reset to 0 like every other register.
  - Reset dominates all inputs while asserted.
- Write:
  - At posedge, if write=1 and rd!=0, Reg[rd] <= write_data.
  - Writes with rd=0 are discarded; Reg[0] reads 0 always.
- Read:
  - At posedge, if read_en=1: out1 <= Reg[rs1] and out2 <= Reg[rs2].
  - Latency 1 cycle.
  - rs1 or rs2 = 0 gives 0.
  - read_en=0: out1/out2 hold their previous values.
  - Read and write in the same cycle are both performed; there is no read/write mode select.
- Same-cycle read/write of the same register (write=1, rd==rsX!=0, read_en=1):
  - Without bypass, outX gets the old value.
  - See Optional Feature for the bypass case.
- Scoreboard (pend[NREGS-1:0]):
  - Set: issue_valid=1 and issue_rd!=0 sets pend[issue_rd] at posedge.
  - Clear: write=1 and rd!=0 clears pend[rd] at posedge.
  - Set and clear on the same index in the same cycle: set wins (a new producer is in flight).
  - Set and clear on different indices: both take effect.
  - pend[0] is constant 0.
  - Writes to a non-pending register are legal and leave pend unchanged (0).
  - Re-issue to an already pending register keeps it pending (single bit, no count).
- busy1/busy2 are combinational: busyX = pend[rsX], with the bypass masking described below.
- Widths: all addresses are AW bits, with no wrap or truncation logic needed; data is XLEN bits, unmodified.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if write=1, rd==rsX, rd!=0 and read_en=1, outX <= write_data (the new value) in the same edge.
  - busyX = pend[rsX] & ~(write & (rd==rsX)), so a consumer is released in the writeback cycle.
  - Exception: if issue_valid=1 and issue_rd==rsX in the same cycle, busyX stays 1.
- Undefined:
  - outX gets the pre-write value.
  - busyX = pend[rsX] exactly; the consumer is released one cycle after writeback.

Test Plan:
- Reset: assert rst mid-run after writing Reg[5]=0xDEADBEEF, then deassert, read rs1=5 -> out1=0, busy1=0; outputs go to 0 immediately on rst, without waiting for a clock edge.
- x0: write=1, rd=0, write_data=0xFFFFFFFF; next cycle read rs1=0, rs2=0 -> out1=out2=0; issue_valid=1, issue_rd=0 -> busy1=0 with rs1=0.
- Dual read and hold:
  - Write Reg[3]=0x11, then Reg[7]=0x22.
  - read_en=1, rs1=3, rs2=7 -> next cycle out1=0x11, out2=0x22.
  - read_en=0 with rs1=7 -> out1 stays 0x11.
- Same-cycle read/write: Reg[4]=0xA; then write 0xB to rd=4 with read_en=1, rs1=4 -> out1=0xB with bypass, 0xA without; the following read gives 0xB in both builds.
- Scoreboard:
  - issue_valid=1, issue_rd=9, then rs1=9 -> busy1=1.
  - Writeback rd=9 -> busy1 drops to 0 in the writeback cycle with bypass, or the cycle after without it.
  - Simultaneous issue_rd=9 and write rd=9 -> busy1 remains 1.
- Parameter sweep: XLEN=64, AW=4; write Reg[15]=0x0123456789ABCDEF, read rs2=15 -> out2 matches; pend has 16 bits, with pend[15] set and cleared correctly.
